writeback_cycle: RTL and testbench

Dual-PE writeback stage placed directly downstream of the memory stage. It selects each PE's result (ALU result or load data). Both results are then serialised onto the single shared register-file write port, in program order, through a small pending buffer. When the buffer is near full, the stage back-pressures the upstream pipeline.

---
 rtl/wb_pkg.sv | 29 ++
 rtl/wb_pending_fifo.sv | 63 ++++++
 rtl/writeback_cycle.sv | 109 ++++++++++
 tb/tb_writeback_cycle.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: buffered RF write entry,
// default buffer depth and result-select encodings.
package wb_pkg;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  localparam int WB_DEPTH = 2;

  localparam logic RESULT_ALU = 1'b0;
  localparam logic RESULT_MEM = 1'b1;

  function automatic logic [31:0] wb_select(input logic        src,
                                            input logic [31:0] alu,
                                            input logic [31:0] mem);
    return (src == RESULT_MEM) ? mem : alu;
  endfunction

  function automatic wb_entry_t wb_make_entry(input logic [4:0]  rd,
                                              input logic [31:0] data);
    wb_entry_t e;
    e.rd   = rd;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/wb_pending_fifo.sv
// Ordered pending-write buffer: shift-down on pop, up to two in-order pushes
// appended behind the surviving entries each cycle.
module wb_pending_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      push_count,
  input  wb_entry_t       push_data0,
  input  wb_entry_t       push_data1,
  input  logic            pop,
  output wb_entry_t       head,
  output logic            head_valid,
  output logic [CW-1:0]   count
);

  wb_entry_t       entries_r     [DEPTH];
  wb_entry_t       shifted_s     [DEPTH];
  wb_entry_t       entries_next_s[DEPTH];
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   base_s;
  logic [CW-1:0]   count_next_s;
  logic            pop_s;

  assign pop_s        = pop & (count_r != {CW{1'b0}});
  assign base_s       = count_r - CW'(pop_s);
  assign count_next_s = base_s + CW'(push_count);

  // Drop the head on pop, then land the pushes in the first free slots.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      shifted_s[i] = pop_s ? entries_r[i+1] : entries_r[i];
    end
    shifted_s[DEPTH-1] = entries_r[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      entries_next_s[i] =
        ((push_count != 2'd0) && (CW'(i) == base_s))               ? push_data0 :
        ((push_count == 2'd2) && (CW'(i) == (base_s + CW'(1))))    ? push_data1 :
                                                                     shifted_s[i];
    end
  end

  // Buffer storage and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '{rd: 5'd0, data: 32'd0};
      end
    end else begin
      count_r   <= count_next_s;
      entries_r <= entries_next_s;
    end
  end

  assign head       = entries_r[0];
  assign head_valid = (count_r != {CW{1'b0}});
  assign count      = count_r;

endmodule

// File: rtl/writeback_cycle.sv
// Dual-PE writeback stage: result muxes, x0/coalesce filtering, and in-order
// serialisation of both PEs onto the single register-file write port.
module writeback_cycle
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         RegWriteW1,
  input  logic                         ResultSrcW1,
  input  logic [4:0]                   RD_W1,
  input  logic [31:0]                  ALU_ResultW1,
  input  logic [31:0]                  ReadDataW1,
  input  logic                         RegWriteW2,
  input  logic                         ResultSrcW2,
  input  logic [4:0]                   RD_W2,
  input  logic [31:0]                  ALU_ResultW2,
  input  logic [31:0]                  ReadDataW2,
  output logic [31:0]                  ResultW1,
  output logic [31:0]                  ResultW2,
  output logic                         StallW,
  output logic                         RF_WE,
  output logic [4:0]                   RF_A,
  output logic [31:0]                  RF_WD,
  output logic [$clog2(DEPTH+1)-1:0]   PendingCount
);

  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t   pe1_s, pe2_s;
  wb_entry_t   head_s, fifo_head_s, push0_s, push1_s;
  logic        v1_raw_s, v2_raw_s, v1_s, v2_s;
  logic        fifo_valid_s, head_valid_s, pop_s;
  logic [1:0]  push_count_s;

  assign ResultW1 = wb_select(ResultSrcW1, ALU_ResultW1, ReadDataW1);
  assign ResultW2 = wb_select(ResultSrcW2, ALU_ResultW2, ReadDataW2);

  // Stall depends on occupancy only, so it never loops back through upstream.
  assign StallW = (PendingCount > CW'(DEPTH - 2));

  assign v1_raw_s = ~StallW & RegWriteW1 & (RD_W1 != 5'd0);
  assign v2_raw_s = ~StallW & RegWriteW2 & (RD_W2 != 5'd0);
  // The younger PE2 write to the same register supersedes PE1.
  assign v1_s     = v1_raw_s & ~(v2_raw_s & (RD_W1 == RD_W2));
  assign v2_s     = v2_raw_s;

  assign pe1_s = wb_make_entry(RD_W1, ResultW1);
  assign pe2_s = wb_make_entry(RD_W2, ResultW2);

  // Pick the oldest pending write for the RF port; the rest go into the buffer.
  always_comb begin
    head_s       = '{rd: 5'd0, data: 32'd0};
    head_valid_s = 1'b0;
    push_count_s = 2'd0;
    push0_s      = pe1_s;
    push1_s      = pe2_s;
    pop_s        = fifo_valid_s;
    if (fifo_valid_s) begin
      head_s       = fifo_head_s;
      head_valid_s = 1'b1;
      push_count_s = {1'b0, v1_s} + {1'b0, v2_s};
      push0_s      = v1_s ? pe1_s : pe2_s;
      push1_s      = pe2_s;
    end else if (v1_s) begin
      head_s       = pe1_s;
      head_valid_s = 1'b1;
      push_count_s = {1'b0, v2_s};
      push0_s      = pe2_s;
      push1_s      = pe2_s;
    end else if (v2_s) begin
      head_s       = pe2_s;
      head_valid_s = 1'b1;
      push_count_s = 2'd0;
    end else begin
      head_valid_s = 1'b0;
      push_count_s = 2'd0;
    end
  end

  wb_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_count (push_count_s),
    .push_data0 (push0_s),
    .push_data1 (push1_s),
    .pop        (pop_s),
    .head       (fifo_head_s),
    .head_valid (fifo_valid_s),
    .count      (PendingCount)
  );

  // Register-file write port; address and data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RF_WE <= 1'b0;
      RF_A  <= 5'd0;
      RF_WD <= 32'd0;
    end else if (head_valid_s) begin
      RF_WE <= 1'b1;
      RF_A  <= head_s.rd;
      RF_WD <= head_s.data;
    end else begin
      RF_WE <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_cycle.sv
// Self-checking bench for writeback_cycle: table vectors, directed multi-cycle
// sequences and random traffic, all compared against a queue-based model.
module tb_writeback_cycle;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          RegWriteW1, ResultSrcW1, RegWriteW2, ResultSrcW2;
  logic [4:0]    RD_W1, RD_W2;
  logic [31:0]   ALU_ResultW1, ReadDataW1, ALU_ResultW2, ReadDataW2;
  logic [31:0]   ResultW1, ResultW2;
  logic          StallW, RF_WE;
  logic [4:0]    RF_A;
  logic [31:0]   RF_WD;
  logic [CW-1:0] PendingCount;

  writeback_cycle #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .RegWriteW1(RegWriteW1), .ResultSrcW1(ResultSrcW1), .RD_W1(RD_W1),
    .ALU_ResultW1(ALU_ResultW1), .ReadDataW1(ReadDataW1),
    .RegWriteW2(RegWriteW2), .ResultSrcW2(ResultSrcW2), .RD_W2(RD_W2),
    .ALU_ResultW2(ALU_ResultW2), .ReadDataW2(ReadDataW2),
    .ResultW1(ResultW1), .ResultW2(ResultW2), .StallW(StallW),
    .RF_WE(RF_WE), .RF_A(RF_A), .RF_WD(RF_WD), .PendingCount(PendingCount)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;

  typedef struct {
    logic rw1, rs1; logic [4:0] rd1; logic [31:0] alu1, rdat1;
    logic rw2, rs2; logic [4:0] rd2; logic [31:0] alu2, rdat2;
    logic [31:0] exp_r1, exp_r2;
    logic exp_we; logic [4:0] exp_a; logic [31:0] exp_wd;
  } vec_t;

  int   n_checks = 0;
  int   n_err    = 0;
  ent_t pend[$];
  ent_t wlog[$];
  logic m_we = 1'b0;
  logic [4:0]  m_a  = 5'd0;
  logic [31:0] m_wd = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_pe1(input logic rw, input logic rs, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rdat);
    RegWriteW1 = rw; ResultSrcW1 = rs; RD_W1 = rd; ALU_ResultW1 = alu; ReadDataW1 = rdat;
  endtask

  task automatic set_pe2(input logic rw, input logic rs, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rdat);
    RegWriteW2 = rw; ResultSrcW2 = rs; RD_W2 = rd; ALU_ResultW2 = alu; ReadDataW2 = rdat;
  endtask

  task automatic idle();
    set_pe1(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    set_pe2(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic tick();
    ent_t lst[$];
    logic stall_m, v1, v2;
    logic [31:0] r1, r2;
    ent_t e;
    #1;
    r1 = ResultSrcW1 ? ReadDataW1 : ALU_ResultW1;
    r2 = ResultSrcW2 ? ReadDataW2 : ALU_ResultW2;
    stall_m = (pend.size() > DEPTH - 2);
    check("ResultW1", ResultW1, r1);
    check("ResultW2", ResultW2, r2);
    check("StallW", 32'(StallW), 32'(stall_m));
    lst = pend;
    v1 = !stall_m && RegWriteW1 && (RD_W1 != 5'd0);
    v2 = !stall_m && RegWriteW2 && (RD_W2 != 5'd0);
    if (v1 && v2 && RD_W1 == RD_W2) v1 = 1'b0;
    if (v1) lst.push_back('{rd: RD_W1, data: r1});
    if (v2) lst.push_back('{rd: RD_W2, data: r2});
    if (lst.size() > 0) begin
      e = lst.pop_front();
      m_we = 1'b1; m_a = e.rd; m_wd = e.data;
    end else begin
      m_we = 1'b0;
    end
    pend = lst;
    @(posedge clk);
    #1;
    check("RF_WE", 32'(RF_WE), 32'(m_we));
    check("RF_A", 32'(RF_A), 32'(m_a));
    check("RF_WD", RF_WD, m_wd);
    check("PendingCount", 32'(PendingCount), 32'(pend.size()));
    if (RF_WE) wlog.push_back('{rd: RF_A, data: RF_WD});
  endtask

  function automatic vec_t mkv(
      input logic rw1, input logic rs1, input logic [4:0] rd1, input logic [31:0] alu1, input logic [31:0] rdat1,
      input logic rw2, input logic rs2, input logic [4:0] rd2, input logic [31:0] alu2, input logic [31:0] rdat2,
      input logic [31:0] er1, input logic [31:0] er2,
      input logic ewe, input logic [4:0] ea, input logic [31:0] ewd);
    vec_t v;
    v.rw1 = rw1; v.rs1 = rs1; v.rd1 = rd1; v.alu1 = alu1; v.rdat1 = rdat1;
    v.rw2 = rw2; v.rs2 = rs2; v.rd2 = rd2; v.alu2 = alu2; v.rdat2 = rdat2;
    v.exp_r1 = er1; v.exp_r2 = er2; v.exp_we = ewe; v.exp_a = ea; v.exp_wd = ewd;
    return v;
  endfunction

  task automatic expect_log(input string name, input logic [4:0] rds[], input logic [31:0] dats[]);
    check({name, "_len"}, 32'(wlog.size()), 32'(rds.size()));
    for (int i = 0; i < rds.size() && i < wlog.size(); i++) begin
      check({name, "_rd"}, 32'(wlog[i].rd), 32'(rds[i]));
      check({name, "_wd"}, wlog[i].data, dats[i]);
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = mkv(1'b1, 1'b1, 5'd5, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0,
                  32'hDEAD_BEEF, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    vecs[1] = mkv(1'b1, 1'b0, 5'd0, 32'h0000_0077, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0,
                  32'h0000_0077, 32'd0, 1'b0, 5'd0, 32'd0);
    vecs[2] = mkv(1'b1, 1'b0, 5'd7, 32'h0000_000A, 32'h99, 1'b1, 1'b0, 5'd7, 32'h0000_000B, 32'h98,
                  32'h0000_000A, 32'h0000_000B, 1'b1, 5'd7, 32'h0000_000B);
    vecs[3] = mkv(1'b0, 1'b0, 5'd3, 32'h1, 32'd0, 1'b1, 1'b1, 5'd9, 32'h2, 32'h0000_0055,
                  32'h1, 32'h0000_0055, 1'b1, 5'd9, 32'h0000_0055);
    vecs[4] = mkv(1'b0, 1'b1, 5'd3, 32'd0, 32'h00C0_FFEE, 1'b1, 1'b0, 5'd0, 32'h5, 32'd0,
                  32'h00C0_FFEE, 32'h5, 1'b0, 5'd0, 32'd0);
    vecs[5] = mkv(1'b1, 1'b0, 5'd0, 32'h3, 32'd0, 1'b1, 1'b1, 5'd0, 32'd0, 32'h4,
                  32'h3, 32'h4, 1'b0, 5'd0, 32'd0);

    idle();
    @(posedge clk);
    #1;
    check("rst_RF_WE", 32'(RF_WE), 32'd0);
    check("rst_RF_A", 32'(RF_A), 32'd0);
    check("rst_RF_WD", RF_WD, 32'd0);
    check("rst_Pending", 32'(PendingCount), 32'd0);
    check("rst_StallW", 32'(StallW), 32'd0);
    rst = 1'b0;

    // Table vectors, each from an empty buffer, then drained.
    for (int i = 0; i < 6; i++) begin
      set_pe1(vecs[i].rw1, vecs[i].rs1, vecs[i].rd1, vecs[i].alu1, vecs[i].rdat1);
      set_pe2(vecs[i].rw2, vecs[i].rs2, vecs[i].rd2, vecs[i].alu2, vecs[i].rdat2);
      #1;
      check("tbl_ResultW1", ResultW1, vecs[i].exp_r1);
      check("tbl_ResultW2", ResultW2, vecs[i].exp_r2);
      tick();
      check("tbl_RF_WE", 32'(RF_WE), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we) begin
        check("tbl_RF_A", 32'(RF_A), 32'(vecs[i].exp_a));
        check("tbl_RF_WD", RF_WD, vecs[i].exp_wd);
      end
      check("tbl_Pending", 32'(PendingCount), 32'd0);
      idle();
      tick();
    end

    // Dual write to different registers.
    set_pe1(1'b1, 1'b0, 5'd3, 32'h11, 32'd0);
    set_pe2(1'b1, 1'b0, 5'd4, 32'h22, 32'd0);
    tick();
    check("dual_a1", 32'(RF_A), 32'd3);
    check("dual_wd1", RF_WD, 32'h11);
    check("dual_cnt1", 32'(PendingCount), 32'd1);
    idle();
    tick();
    check("dual_we2", 32'(RF_WE), 32'd1);
    check("dual_a2", 32'(RF_A), 32'd4);
    check("dual_wd2", RF_WD, 32'h22);
    check("dual_cnt2", 32'(PendingCount), 32'd0);
    tick();

    // Back-pressure: three dual writes, re-presented while stalled.
    wlog.delete();
    set_pe1(1'b1, 1'b0, 5'd1, 32'h101, 32'd0);
    set_pe2(1'b1, 1'b0, 5'd2, 32'h102, 32'd0);
    tick();
    check("bp_stall_rise", 32'(StallW), 32'd1);
    for (int k = 0; k < 2; k++) begin
      set_pe1(1'b1, 1'b0, 5'(3 + 2 * k), 32'h103 + 32'(2 * k), 32'd0);
      set_pe2(1'b1, 1'b0, 5'(4 + 2 * k), 32'h104 + 32'(2 * k), 32'd0);
      tick();
      tick();
    end
    idle();
    tick();
    tick();
    expect_log("bp", '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6},
               '{32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106});

    // A younger single write must follow the buffered entry.
    wlog.delete();
    set_pe1(1'b1, 1'b0, 5'd10, 32'hA0, 32'd0);
    set_pe2(1'b1, 1'b1, 5'd11, 32'd0, 32'hA1);
    tick();
    set_pe1(1'b1, 1'b0, 5'd12, 32'hA2, 32'd0);
    set_pe2(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    tick();
    idle();
    tick();
    expect_log("order", '{5'd10, 5'd11, 5'd12}, '{32'hA0, 32'hA1, 32'hA2});

    // Reset while a write is still buffered.
    set_pe1(1'b1, 1'b0, 5'd20, 32'hB0, 32'd0);
    set_pe2(1'b1, 1'b0, 5'd21, 32'hB1, 32'd0);
    tick();
    idle();
    #2 rst = 1'b1;
    #1;
    check("rmid_RF_WE", 32'(RF_WE), 32'd0);
    check("rmid_RF_A", 32'(RF_A), 32'd0);
    check("rmid_RF_WD", RF_WD, 32'd0);
    check("rmid_Pending", 32'(PendingCount), 32'd0);
    check("rmid_StallW", 32'(StallW), 32'd0);
    pend.delete();
    m_we = 1'b0; m_a = 5'd0; m_wd = 32'd0;
    @(posedge clk);
    #1 rst = 1'b0;
    wlog.delete();
    for (int k = 0; k < 3; k++) tick();
    check("rmid_no_writes", 32'(wlog.size()), 32'd0);

    // Random traffic; held inputs are re-presented while stalled.
    for (int k = 0; k < 400; k++) begin
      if (pend.size() <= DEPTH - 2) begin
        set_pe1(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)),
                $urandom, $urandom);
        set_pe2(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)),
                $urandom, $urandom);
      end
      tick();
    end
    idle();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
